// File: rtl/cpu_if_pkg.sv
// Shared fetch-stage definitions: default address/instruction widths, the
// reset fetch address, the bubble instruction and the prefetch queue entry.
package cpu_if_pkg;

    localparam int ADDR_W = 30;
    localparam int INSN_W = 32;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 30'h0000_0000;
    localparam logic [INSN_W-1:0] NOP_INSN     = 32'h0000_0000;

    // One buffered fetch: the word address it came from and the instruction.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } if_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO holding prefetched instructions.
// Ports: clk/reset (sync, active-high); push/wdata write an entry, pop drops the
// head, clear empties the queue and wins over push/pop in the same cycle;
// rdata is the head entry (only meaningful when !empty); full/empty/count
// report occupancy. DEPTH must be a power of two so the pointers wrap freely.
module if_sync_fifo #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign full      = (cnt_r == CNT_FULL);
    assign empty     = (cnt_r == '0);
    assign count     = cnt_r;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; clear behaves like a reset of the queue.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            wr_ptr_r <= push_ok_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
            rd_ptr_r <= pop_ok_s  ? rd_ptr_r + PTR_ONE : rd_ptr_r;
            if (push_ok_s && !pop_ok_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else if (!push_ok_s && pop_ok_s) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Entry storage; data is only observed through count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear && !reset) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer: issues sequential word fetches to an in-order,
// variable-latency memory and queues the responses for decode.
// Ports: clk/reset (sync, active-high); mem_req/mem_addr/mem_rdy request side;
// mem_rvalid/mem_rdata response side; stall holds the head entry;
// flush/new_pc and br_taken/br_addr redirect fetch (flush wins);
// if_en/if_pc/if_insn present the head of the queue to decode.
module if_prefetch_buf #(
    parameter int                ADDR_W       = cpu_if_pkg::ADDR_W,
    parameter int                INSN_W       = cpu_if_pkg::INSN_W,
    parameter int                DEPTH        = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = cpu_if_pkg::RESET_VECTOR,
    parameter logic [INSN_W-1:0] NOP_INSN     = cpu_if_pkg::NOP_INSN
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rdy,
    input  logic              mem_rvalid,
    input  logic [INSN_W-1:0] mem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INSN_W-1:0] if_insn,
    output logic              if_en
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]     CNT_ZERO = CW'(1'b0);
    localparam logic [CW:0]       DEPTH_C  = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1'b1);

    logic [ADDR_W-1:0]        fp_r;       // next fetch address
    logic [ADDR_W-1:0]        rp_r;       // PC of the next response to be queued
    logic [CW-1:0]            out_r;      // requests accepted, response not yet seen
    logic [CW-1:0]            drop_r;     // stale responses still to be discarded
    logic [CW-1:0]            out_nxt_s;
    logic [CW-1:0]            drop_nxt_s;
    logic [CW-1:0]            rv_dec_s;
    logic [CW-1:0]            fifo_count_s;
    logic [ADDR_W+INSN_W-1:0] head_s;
    logic                     redirect_s;
    logic [ADDR_W-1:0]        target_s;
    logic                     rv_ok_s;
    logic                     issue_ok_s;
    logic                     accept_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     fifo_empty_s;
    logic                     fifo_full_s;

    assign redirect_s = flush | br_taken;
    assign target_s   = flush ? new_pc : br_addr;

    // A response with nothing outstanding is spurious (e.g. left over from
    // before reset) and must not touch any state.
    assign rv_ok_s  = mem_rvalid && (out_r != CNT_ZERO);
    assign rv_dec_s = rv_ok_s ? CNT_ONE : CNT_ZERO;

    // Reserving a queue slot for every in-flight request means a response
    // always finds room, so memory never needs backpressure.
    assign issue_ok_s = ({1'b0, fifo_count_s} + {1'b0, out_r}) < DEPTH_C;
    assign mem_req    = !reset && !redirect_s && (drop_r == CNT_ZERO) && issue_ok_s;
    assign mem_addr   = fp_r;
    assign accept_s   = mem_req && mem_rdy;

    // Full cannot occur here given the issue rule; the guard keeps rp honest anyway.
    assign push_s = rv_ok_s && (drop_r == CNT_ZERO) && !redirect_s && !fifo_full_s;
    assign pop_s  = !fifo_empty_s && !stall;

    assign if_en   = !fifo_empty_s;
    assign if_pc   = fifo_empty_s ? rp_r : head_s[INSN_W +: ADDR_W];
    assign if_insn = fifo_empty_s ? NOP_INSN : head_s[INSN_W-1:0];

    // Next outstanding count: +1 per accepted request, -1 per valid response.
    always_comb begin
        out_nxt_s = out_r;
        if (accept_s && !rv_ok_s) begin
            out_nxt_s = out_r + CNT_ONE;
        end else if (!accept_s && rv_ok_s) begin
            out_nxt_s = out_r - CNT_ONE;
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Next drop count: on redirect every response still in flight becomes stale.
    always_comb begin
        drop_nxt_s = drop_r;
        if (redirect_s) begin
            drop_nxt_s = out_r - rv_dec_s;
        end else if ((drop_r != CNT_ZERO) && rv_ok_s) begin
            drop_nxt_s = drop_r - CNT_ONE;
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // Fetch/response PC and in-flight bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fp_r   <= RESET_VECTOR;
            rp_r   <= RESET_VECTOR;
            out_r  <= CNT_ZERO;
            drop_r <= CNT_ZERO;
        end else if (redirect_s) begin
            fp_r   <= target_s;
            rp_r   <= target_s;
            out_r  <= out_nxt_s;
            drop_r <= drop_nxt_s;
        end else begin
            fp_r   <= accept_s ? fp_r + PC_ONE : fp_r;
            rp_r   <= push_s   ? rp_r + PC_ONE : rp_r;
            out_r  <= out_nxt_s;
            drop_r <= drop_nxt_s;
        end
    end

    if_sync_fifo #(
        .WIDTH (ADDR_W + INSN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .clear (redirect_s),
        .wdata ({rp_r, mem_rdata}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

endmodule
